// File: rtl/pc_fetch_seq.sv
// Fetch-address sequencer: holds a request until imem accepts it, buffers one redirect, steers exceptions.
// Optional feature: define PC_EPC_EN to capture the exception PC on the epc port.
module pc_fetch_seq #(
    parameter int          AW           = 32,
    parameter logic [AW-1:0] RESET_VECTOR = AW'(32'h0000_0000),
    parameter logic [AW-1:0] EXC_VECTOR   = AW'(32'h8000_0180)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          imem_ready,
    output logic          imem_valid,
    output logic [AW-1:0] pc,
    input  logic [AW-1:0] d_pc,
    input  logic          jump,
    input  logic [25:0]   fd_Inst_25_0,
    input  logic          branch,
    input  logic [AW-1:0] fd_br_signext_sl2,
    input  logic          jump_reg,
    input  logic [AW-1:0] gpr_rd_data1,
    input  logic          exc,
    output logic [AW-1:0] d_pc_plus_8,
    output logic          redirect_pending,
    output logic          misalign_exc,
    output logic [AW-1:0] epc
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        IDLE = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pend_target;
    logic          pend_exc;

    logic [AW-1:0] seq_pc_plus_4;
    logic [AW-1:0] d_pc_plus_4;
    logic          active;
    logic          jr_misaligned;
    logic          live_valid;
    logic          live_exc;
    logic [AW-1:0] live_target;
    logic          pend_write_ok;

    // Redirect target selection; redirects are ignored until the first request is issued.
    always_comb begin
        seq_pc_plus_4 = pc + AW'(4);
        d_pc_plus_4   = d_pc + AW'(4);
        d_pc_plus_8   = d_pc + AW'(8);
        active        = (state != BOOT);
        jr_misaligned = jump_reg && (gpr_rd_data1[1:0] != 2'b00) && !exc;
        live_valid    = active && (exc || jump_reg || branch || jump);
        live_exc      = active && (exc || jr_misaligned);
        if (exc || jr_misaligned) begin
            live_target = EXC_VECTOR;
        end else if (jump_reg) begin
            live_target = gpr_rd_data1;
        end else if (branch) begin
            live_target = d_pc_plus_4 + fd_br_signext_sl2;
        end else begin
            live_target = {d_pc_plus_4[AW-1:28], fd_Inst_25_0, 2'b00};
        end
        // A buffered exception may only be displaced by another exception.
        if (redirect_pending && pend_exc) begin
            pend_write_ok = live_exc;
        end else begin
            pend_write_ok = 1'b1;
        end
    end

    // Fetch FSM, pc register and one-entry redirect buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= BOOT;
            pc               <= RESET_VECTOR;
            imem_valid       <= 1'b0;
            redirect_pending <= 1'b0;
            pend_target      <= RESET_VECTOR;
            pend_exc         <= 1'b0;
            misalign_exc     <= 1'b0;
        end else begin
            misalign_exc <= active && jr_misaligned;
            case (state)
                BOOT: begin
                    state      <= stall ? IDLE : REQ;
                    imem_valid <= !stall;
                end
                REQ: begin
                    if (imem_ready) begin
                        if (live_valid) begin
                            pc <= live_target;
                        end else if (redirect_pending) begin
                            pc <= pend_target;
                        end else begin
                            pc <= seq_pc_plus_4;
                        end
                        redirect_pending <= 1'b0;
                        pend_exc         <= 1'b0;
                        state            <= stall ? IDLE : REQ;
                        imem_valid       <= !stall;
                    end else begin
                        // Request must stay stable: park the redirect instead of moving pc.
                        if (live_valid && pend_write_ok) begin
                            pend_target      <= live_target;
                            pend_exc         <= live_exc;
                            redirect_pending <= 1'b1;
                        end
                        state      <= REQ;
                        imem_valid <= 1'b1;
                    end
                end
                IDLE: begin
                    if (live_valid) begin
                        pc               <= live_target;
                        redirect_pending <= 1'b0;
                        pend_exc         <= 1'b0;
                    end else if (redirect_pending) begin
                        pc               <= pend_target;
                        redirect_pending <= 1'b0;
                        pend_exc         <= 1'b0;
                    end
                    state      <= stall ? IDLE : REQ;
                    imem_valid <= !stall;
                end
                default: begin
                    state      <= BOOT;
                    imem_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_EPC_EN
    // Exception PC: faulting instruction for exc, faulting target for a misaligned jump-register.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= '0;
        end else if (live_exc) begin
            epc <= exc ? d_pc : gpr_rd_data1;
        end
    end
`else
    assign epc = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Scoreboard bench for pc_fetch_seq: expected pc values are queued at drive time and popped after the edge.
module tb_pc_fetch_seq;

    localparam logic [31:0] EXC_V = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst, stall, imem_ready, imem_valid;
    logic [31:0] pc, d_pc, fd_br_signext_sl2, gpr_rd_data1, d_pc_plus_8, epc;
    logic        jump, branch, jump_reg, exc, redirect_pending, misalign_exc;
    logic [25:0] fd_Inst_25_0;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] exp_epc;
    int          n_checks = 0;
    int          n_errors = 0;

    pc_fetch_seq dut (
        .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
        .imem_valid(imem_valid), .pc(pc), .d_pc(d_pc), .jump(jump),
        .fd_Inst_25_0(fd_Inst_25_0), .branch(branch),
        .fd_br_signext_sl2(fd_br_signext_sl2), .jump_reg(jump_reg),
        .gpr_rd_data1(gpr_rd_data1), .exc(exc), .d_pc_plus_8(d_pc_plus_8),
        .redirect_pending(redirect_pending), .misalign_exc(misalign_exc), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        jump = 1'b0; branch = 1'b0; jump_reg = 1'b0; exc = 1'b0;
        d_pc = 32'h0; fd_Inst_25_0 = 26'h0; fd_br_signext_sl2 = 32'h0; gpr_rd_data1 = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; imem_ready = 1'b1;
        clear_redirects();
        tick(); tick();
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_checks++; if (imem_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", imem_valid); end
        n_checks++; if (redirect_pending !== 1'b0) begin n_errors++; $display("FAIL reset_pending: got %b want 0", redirect_pending); end
        n_checks++; if (misalign_exc !== 1'b0) begin n_errors++; $display("FAIL reset_misalign: got %b want 0", misalign_exc); end
        n_checks++; if (epc !== 32'h0) begin n_errors++; $display("FAIL reset_epc: got %h want 0", epc); end
    endtask

    task automatic test_boot_seq();
        rst = 1'b0;
        // BOOT occupies the first cycle after release; then 0,4,8,12,16 with a request each cycle.
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = exp_q.pop_front();
            n_checks++; if (pc !== exp || imem_valid !== 1'b1) begin
                n_errors++; $display("FAIL boot_seq%0d: got pc=%h valid=%b want pc=%h valid=1", i, pc, imem_valid, exp);
            end
        end
    endtask

    task automatic test_pending_branch();
        imem_ready = 1'b0; branch = 1'b1; d_pc = 32'h0C; fd_br_signext_sl2 = 32'h20;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h10);
        exp_q.push_back(32'h30);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) clear_redirects();
            exp = exp_q.pop_front();
            n_checks++; if (pc !== exp || redirect_pending !== 1'b1 || imem_valid !== 1'b1) begin
                n_errors++; $display("FAIL hold%0d: got pc=%h pend=%b valid=%b want pc=%h pend=1 valid=1", i, pc, redirect_pending, imem_valid, exp);
            end
        end
        imem_ready = 1'b1;
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || redirect_pending !== 1'b0) begin
            n_errors++; $display("FAIL hold_accept: got pc=%h pend=%b want pc=%h pend=0", pc, redirect_pending, exp);
        end
    endtask

    task automatic test_targets();
        logic [31:0] dp;
        logic [25:0] idx;
        dp = 32'h1000_0100; idx = 26'h0AB_CDE;
        d_pc = dp; fd_Inst_25_0 = idx; jump = 1'b1;
        exp_q.push_back(((dp + 32'd4) & 32'hF000_0000) | {4'h0, idx, 2'b00});
        tick(); clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp) begin n_errors++; $display("FAIL jump: got %h want %h", pc, exp); end

        d_pc = 32'h200; fd_br_signext_sl2 = 32'hFFFF_FFF8; branch = 1'b1;
        exp_q.push_back(32'h1FC);
        tick(); clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp) begin n_errors++; $display("FAIL branch_neg: got %h want %h", pc, exp); end

        d_pc = 32'h300; fd_br_signext_sl2 = 32'h40; branch = 1'b1; jump = 1'b1;
        jump_reg = 1'b1; gpr_rd_data1 = 32'h2000;
        exp_q.push_back(32'h2000);
        tick(); clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || misalign_exc !== 1'b0) begin
            n_errors++; $display("FAIL jr_prio: got pc=%h mis=%b want pc=%h mis=0", pc, misalign_exc, exp);
        end

        d_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++; if (d_pc_plus_8 !== 32'h4) begin n_errors++; $display("FAIL plus8_wrap: got %h want %h", d_pc_plus_8, 32'h4); end
        d_pc = 32'h0000_1234;
        #1;
        n_checks++; if (d_pc_plus_8 !== 32'h0000_123C) begin n_errors++; $display("FAIL plus8: got %h want %h", d_pc_plus_8, 32'h123C); end

        jump_reg = 1'b1; gpr_rd_data1 = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        tick(); clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp) begin n_errors++; $display("FAIL wrap_load: got %h want %h", pc, exp); end
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp) begin n_errors++; $display("FAIL wrap_inc: got %h want %h", pc, exp); end
    endtask

    task automatic test_exc_priority();
        d_pc = 32'h40; exc = 1'b1; jump = 1'b1; fd_Inst_25_0 = 26'h123;
        branch = 1'b1; fd_br_signext_sl2 = 32'h100;
`ifdef PC_EPC_EN
        exp_epc = 32'h40;
`else
        exp_epc = 32'h0;
`endif
        exp_q.push_back(EXC_V);
        tick(); clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp) begin n_errors++; $display("FAIL exc_pc: got %h want %h", pc, exp); end
        n_checks++; if (epc !== exp_epc) begin n_errors++; $display("FAIL exc_epc: got %h want %h", epc, exp_epc); end
        n_checks++; if (misalign_exc !== 1'b0) begin n_errors++; $display("FAIL exc_nomis: got %b want 0", misalign_exc); end
    endtask

    task automatic test_misalign();
        d_pc = 32'h500; jump_reg = 1'b1; gpr_rd_data1 = 32'h1002;
`ifdef PC_EPC_EN
        exp_epc = 32'h1002;
`else
        exp_epc = 32'h0;
`endif
        exp_q.push_back(EXC_V);
        exp_q.push_back(EXC_V + 32'd4);
        tick(); clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || misalign_exc !== 1'b1) begin
            n_errors++; $display("FAIL misalign: got pc=%h mis=%b want pc=%h mis=1", pc, misalign_exc, exp);
        end
        n_checks++; if (epc !== exp_epc) begin n_errors++; $display("FAIL misalign_epc: got %h want %h", epc, exp_epc); end
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || misalign_exc !== 1'b0) begin
            n_errors++; $display("FAIL misalign_end: got pc=%h mis=%b want pc=%h mis=0", pc, misalign_exc, exp);
        end
    endtask

    task automatic test_stall_idle();
        stall = 1'b1; imem_ready = 1'b0;
        exp_q.push_back(32'h8000_0184);
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || imem_valid !== 1'b1) begin
            n_errors++; $display("FAIL stall_req: got pc=%h valid=%b want pc=%h valid=1", pc, imem_valid, exp);
        end
        imem_ready = 1'b1;
        exp_q.push_back(32'h8000_0188);
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || imem_valid !== 1'b0) begin
            n_errors++; $display("FAIL stall_accept: got pc=%h valid=%b want pc=%h valid=0", pc, imem_valid, exp);
        end
        d_pc = 32'h100; fd_br_signext_sl2 = 32'h10; branch = 1'b1;
        exp_q.push_back(32'h114);
        tick(); clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || imem_valid !== 1'b0) begin
            n_errors++; $display("FAIL idle_redirect: got pc=%h valid=%b want pc=%h valid=0", pc, imem_valid, exp);
        end
        stall = 1'b0;
        exp_q.push_back(32'h114);
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || imem_valid !== 1'b1) begin
            n_errors++; $display("FAIL idle_resume: got pc=%h valid=%b want pc=%h valid=1", pc, imem_valid, exp);
        end
    endtask

    task automatic test_pending_exc();
        imem_ready = 1'b0; exc = 1'b1; d_pc = 32'h300;
        exp_q.push_back(32'h114);
        exp_q.push_back(32'h114);
        exp_q.push_back(EXC_V);
        tick();
        clear_redirects();
        branch = 1'b1; d_pc = 32'h500; fd_br_signext_sl2 = 32'h40;
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || redirect_pending !== 1'b1) begin
            n_errors++; $display("FAIL pexc_hold: got pc=%h pend=%b want pc=%h pend=1", pc, redirect_pending, exp);
        end
        tick();
        clear_redirects();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || redirect_pending !== 1'b1) begin
            n_errors++; $display("FAIL pexc_branch: got pc=%h pend=%b want pc=%h pend=1", pc, redirect_pending, exp);
        end
        imem_ready = 1'b1;
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || redirect_pending !== 1'b0) begin
            n_errors++; $display("FAIL pexc_accept: got pc=%h pend=%b want pc=%h pend=0", pc, redirect_pending, exp);
        end
    endtask

    task automatic test_rst_pending();
        imem_ready = 1'b0; branch = 1'b1; d_pc = 32'h10; fd_br_signext_sl2 = 32'h0;
        tick();
        n_checks++; if (redirect_pending !== 1'b1) begin n_errors++; $display("FAIL rp_setup: got %b want 1", redirect_pending); end
        rst = 1'b1;
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front();
        n_checks++; if (pc !== exp || redirect_pending !== 1'b0 || imem_valid !== 1'b0) begin
            n_errors++; $display("FAIL rp_reset: got pc=%h pend=%b valid=%b want pc=%h pend=0 valid=0", pc, redirect_pending, imem_valid, exp);
        end
        rst = 1'b0; clear_redirects(); imem_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = exp_q.pop_front();
            n_checks++; if (pc !== exp || imem_valid !== 1'b1) begin
                n_errors++; $display("FAIL rp_restart%0d: got pc=%h valid=%b want pc=%h valid=1", i, pc, imem_valid, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_pending_branch();
        test_targets();
        test_exc_priority();
        test_misalign();
        test_stall_idle();
        test_pending_exc();
        test_rst_pending();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
PC_FETCH_SEQ -- requirements
Module: pc_fetch_seq

Interface
REQ-001 SHALL have parameters AW (default 32, PC width, at least 30), RESET_VECTOR (default 32'h0000_0000, first fetch address) and EXC_VECTOR (default 32'h8000_0180, exception entry address).
REQ-002 SHALL have ports: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-003 SHALL have ports: stall in 1 hazard hold; imem_ready in 1 instruction memory accepts request; imem_valid out 1 fetch request valid; pc out AW fetch address.
REQ-004 SHALL have ports: d_pc in AW decode-stage instruction PC; jump in 1; fd_Inst_25_0 in 26 jump index; branch in 1; fd_br_signext_sl2 in AW branch offset; jump_reg in 1; gpr_rd_data1 in AW jump-register target; exc in 1 exception request.
REQ-005 SHALL have ports: d_pc_plus_8 out AW link address; redirect_pending out 1 buffered redirect flag; misalign_exc out 1 one-cycle misaligned-JR pulse; epc out AW exception PC.
REQ-006 Clock and reset SHALL be named clk and rst, with one clock and a synchronous active-high reset.

Function
REQ-007 d_pc_plus_8 SHALL equal d_pc+8 combinationally, modulo 2^AW.
REQ-008 Targets SHALL be: branch = d_pc+4+fd_br_signext_sl2 (mod 2^AW); jump = {(d_pc+4)[AW-1:28], fd_Inst_25_0, 2'b00}; jump_reg = gpr_rd_data1; exc = EXC_VECTOR.
REQ-009 Live redirect priority SHALL be exc > jump_reg > branch > jump, and a jump_reg target with [1:0]!=0 SHALL be replaced by EXC_VECTOR with misalign_exc asserted for exactly that cycle.
REQ-010 The FSM SHALL have three states: BOOT (imem_valid=0), REQ (imem_valid=1) and IDLE (imem_valid=0).
REQ-011 BOOT SHALL go to IDLE if stall=1, otherwise to REQ, one cycle after reset deasserts.
REQ-012 In REQ with imem_ready=0, pc SHALL hold unchanged and the state SHALL remain REQ, so the request stays stable until accepted.
REQ-013 In REQ with imem_ready=1 (accept), pc SHALL load the live redirect target if any, else the pending target if any, else pc+4; the next state SHALL be IDLE if stall=1, else REQ.
REQ-014 A live redirect in REQ with imem_ready=0 SHALL be written to a one-entry pending buffer and SHALL set redirect_pending=1 from the next cycle.
REQ-015 A newer redirect SHALL overwrite the pending entry, except that a pending exc/misalign entry SHALL be overwritten only by another exc.
REQ-016 The pending buffer SHALL clear on the cycle its target is loaded into pc.
REQ-017 In IDLE, a live redirect SHALL load pc directly next cycle, otherwise a pending target SHALL load; IDLE SHALL go to REQ when stall=0.
REQ-018 stall SHALL never deassert imem_valid while in REQ; it SHALL only prevent a new request after acceptance.
REQ-019 pc SHALL wrap modulo 2^AW on increment.

Reset
REQ-020 On rst=1 at a clk edge, the block SHALL set pc=RESET_VECTOR, state=BOOT, imem_valid=0, pending cleared, redirect_pending=0, misalign_exc=0 and epc=0.
REQ-021 rst SHALL override every input, including rst asserted mid-request or while a redirect is pending, and the pending redirect SHALL be discarded.

Configuration
REQ-022 Macro PC_EPC_EN defined: epc SHALL load d_pc on a live exc or misaligned jump_reg, and gpr_rd_data1 (the faulting target) when misaligned; it SHALL hold otherwise.
REQ-023 Macro PC_EPC_EN undefined: the epc port SHALL remain present and be tied to 0, with no capture registers.

Verification
REQ-024 The bench SHALL cover reset release with stall=0 and imem_ready=1: BOOT 1 cycle, then pc=0,4,8,12 on successive cycles with imem_valid=1.
REQ-025 The bench SHALL cover imem_ready=0 for 3 cycles at pc=0x10 with branch=1, d_pc=0x0C, offset=0x20: pc holds 0x10, redirect_pending=1, and after accept pc=0x30.
REQ-026 The bench SHALL cover simultaneous jump and branch with exc=1: pc=0x8000_0180 next cycle and, with PC_EPC_EN, epc=d_pc.
REQ-027 The bench SHALL cover jump_reg with gpr_rd_data1=0x1002: misalign_exc pulses 1 cycle, pc=EXC_VECTOR and, with PC_EPC_EN, epc=0x1002.
REQ-028 The bench SHALL cover pending exc followed by branch while imem_ready=0: after accept, pc=EXC_VECTOR (branch ignored).
REQ-029 The bench SHALL cover rst asserted while redirect_pending=1: next cycle pc=RESET_VECTOR, redirect_pending=0, imem_valid=0.
